// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU bit-shift group: widths and the state
// encoding used by the sequential shifters.
package alu_shift_pkg;
    localparam int SHIFT_WIDTH = 20;
    localparam int SHIFT_AMT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;
endpackage

// File: rtl/shift_right_step.sv
// Combinational one-position right shift; the vacated MSB takes the fill bit.
module shift_right_step #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);
    assign dout[WIDTH-1] = fill;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign dout[gi] = din[gi+1];
        end
    endgenerate
endmodule

// File: rtl/shift_right_seq.sv
// Iterative logical/arithmetic right shifter: one bit per clock, with a
// start/busy/done handshake and a result register that holds until the next completion.
module shift_right_seq
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c
);
    shift_state_t     state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             fill_reg, fill_next;
    logic [WIDTH-1:0] c_reg, c_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] work_shifted;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .din  (work_reg),
        .fill (fill_reg),
        .dout (work_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            fill_reg  <= 1'b0;
            c_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            fill_reg  <= fill_next;
            c_reg     <= c_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        fill_next  = fill_reg;
        c_next     = c_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // A start in the done cycle is accepted, giving back-to-back operation.
                if (start) begin
                    work_next  = a;
                    cnt_next   = b;
                    fill_next  = arith & a[WIDTH-1];
                    state_next = SHIFT;
                    busy_next  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_reg == '0) begin
                    c_next     = work_reg;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    work_next = work_shifted;
                    cnt_next  = cnt_reg - SHW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign c    = c_reg;
endmodule
